quant_relu_cell: RTL and testbench

Quantization-aware successor to the unquantized ReLU output cell. Takes signed accumulator results from the systolic MAC array and requantizes each one to an unsigned DATA_WIDTH activation: fixed-point multiply, rounding right shift, zero-point add, then a mode-selected clamp (none, ReLU, capped ReLU). Each output is tagged with a wrapping neuron index and an end-of-row flag, ready for write-back to the activation buffer.

---
 rtl/quant_relu_cell.sv | 178 +++++++++++++++++
 tb/tb_quant_relu_cell.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/quant_relu_cell.sv
// Requantizing ReLU output cell: fixed-point scale, rounding shift, zero-point add and
// mode-selected clamp, with a wrapping neuron index and end-of-row flag.
module quant_relu_cell #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int MULT_WIDTH   = 16,
  parameter int SHIFT_WIDTH  = 5,
  parameter int INDEX_WIDTH  = 10,
  parameter int CELL_AMOUNT  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_valid,
  input  logic [RESULT_WIDTH-1:0] input_result,
  input  logic                    index_clear,
  input  logic [MULT_WIDTH-1:0]   cfg_mult,
  input  logic [SHIFT_WIDTH-1:0]  cfg_shift,
  input  logic [DATA_WIDTH-1:0]   cfg_zero_point,
  input  logic [1:0]              cfg_mode,
  input  logic [DATA_WIDTH-1:0]   cfg_cap,
  output logic [DATA_WIDTH-1:0]   output_value,
  output logic [INDEX_WIDTH-1:0]  output_index,
  output logic                    output_enable,
  output logic                    output_last
);

  localparam int PW = RESULT_WIDTH + MULT_WIDTH + 1;  // full signed product
  localparam int RW = PW + 1;                         // guard bit for the rounding bias
  localparam int SW = RW + 1;                         // room for the zero-point add
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX  = INDEX_WIDTH'(CELL_AMOUNT - 1);
  localparam logic [INDEX_WIDTH-1:0] FIRST_INC = (CELL_AMOUNT == 1) ? '0 : INDEX_WIDTH'(1);
  localparam logic [RW-1:0]          ONE_RW    = {{(RW-1){1'b0}}, 1'b1};

  function automatic logic [INDEX_WIDTH-1:0] wrap_inc(input logic [INDEX_WIDTH-1:0] cur);
    if (cur == LAST_IDX) begin
      wrap_inc = '0;
    end else begin
      wrap_inc = cur + INDEX_WIDTH'(1);
    end
  endfunction

  logic [INDEX_WIDTH-1:0] cnt_r;
  logic [INDEX_WIDTH-1:0] cnt_nxt_s;
  logic [INDEX_WIDTH-1:0] idx_s;
  logic signed [PW-1:0]   prod_s;

  logic                   vld1_r;
  logic signed [PW-1:0]   prod1_r;
  logic [INDEX_WIDTH-1:0] idx1_r;
  logic [SHIFT_WIDTH-1:0] shift1_r;
  logic [DATA_WIDTH-1:0]  zp1_r;
  logic [1:0]             mode1_r;
  logic [DATA_WIDTH-1:0]  cap1_r;

  logic signed [RW-1:0]   ext_s;
  logic signed [RW-1:0]   bias_s;
  logic signed [RW-1:0]   rnd_s;

  logic                   vld2_r;
  logic signed [RW-1:0]   rnd2_r;
  logic [INDEX_WIDTH-1:0] idx2_r;
  logic [DATA_WIDTH-1:0]  zp2_r;
  logic [1:0]             mode2_r;
  logic [DATA_WIDTH-1:0]  cap2_r;

  logic signed [SW-1:0]   sum_s;
  logic signed [SW-1:0]   lo_s;
  logic signed [SW-1:0]   hi_s;
  logic signed [SW-1:0]   min_s;
  logic [DATA_WIDTH-1:0]  lo_u_s;
  logic [DATA_WIDTH-1:0]  val_s;

  // Stage 1 product and index assignment; a clear alongside a valid hands that sample index 0
  always_comb begin
    prod_s    = PW'($signed(input_result)) * PW'($signed({1'b0, cfg_mult}));
    idx_s     = cnt_r;
    cnt_nxt_s = cnt_r;
    if (index_clear) begin
      idx_s     = '0;
      cnt_nxt_s = input_valid ? FIRST_INC : '0;
    end else if (input_valid) begin
      cnt_nxt_s = wrap_inc(cnt_r);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Stage 2 rounding shift, half toward +infinity
  always_comb begin
    ext_s  = RW'(prod1_r);
    bias_s = '0;
    rnd_s  = ext_s;
    if (shift1_r == '0) begin
      rnd_s = ext_s;
    end else begin
      bias_s = $signed(ONE_RW << (shift1_r - SHIFT_WIDTH'(1)));
      rnd_s  = (ext_s + bias_s) >>> shift1_r;
    end
  end

  // Stage 3 zero-point add and clamp; applying lo last lets it win over a cap below zero point
  always_comb begin
    sum_s = SW'(rnd2_r) + $signed({{(SW-DATA_WIDTH){1'b0}}, zp2_r});
    case (mode2_r)
      2'd0:    lo_u_s = '0;
      default: lo_u_s = zp2_r;
    endcase
    case (mode2_r)
      2'd2:    hi_s = $signed({{(SW-DATA_WIDTH){1'b0}}, cap2_r});
      default: hi_s = $signed({{(SW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}});
    endcase
    lo_s = $signed({{(SW-DATA_WIDTH){1'b0}}, lo_u_s});
    if (sum_s > hi_s) begin
      min_s = hi_s;
    end else begin
      min_s = sum_s;
    end
    if (min_s < lo_s) begin
      val_s = lo_u_s;
    end else begin
      val_s = min_s[DATA_WIDTH-1:0];
    end
  end

  // Pipeline registers, index counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r         <= '0;
      vld1_r        <= 1'b0;
      prod1_r       <= '0;
      idx1_r        <= '0;
      shift1_r      <= '0;
      zp1_r         <= '0;
      mode1_r       <= 2'd0;
      cap1_r        <= '0;
      vld2_r        <= 1'b0;
      rnd2_r        <= '0;
      idx2_r        <= '0;
      zp2_r         <= '0;
      mode2_r       <= 2'd0;
      cap2_r        <= '0;
      output_value  <= '0;
      output_index  <= '0;
      output_enable <= 1'b0;
      output_last   <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      vld1_r <= input_valid;
      if (input_valid) begin
        prod1_r  <= prod_s;
        idx1_r   <= idx_s;
        shift1_r <= cfg_shift;
        zp1_r    <= cfg_zero_point;
        mode1_r  <= cfg_mode;
        cap1_r   <= cfg_cap;
      end
      vld2_r <= vld1_r;
      if (vld1_r) begin
        rnd2_r  <= rnd_s;
        idx2_r  <= idx1_r;
        zp2_r   <= zp1_r;
        mode2_r <= mode1_r;
        cap2_r  <= cap1_r;
      end
      output_enable <= vld2_r;
      if (vld2_r) begin
        output_value <= val_s;
        output_index <= idx2_r;
        output_last  <= (idx2_r == LAST_IDX);
      end else begin
        output_value <= '0;
        output_index <= '0;
        output_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quant_relu_cell.sv
// Directed bench for quant_relu_cell: hand-computed requantization results, index
// wrapping, latency, idle zeroing and asynchronous reset flush.
module tb_quant_relu_cell;

  localparam int DW = 8;
  localparam int RW = 16;
  localparam int MW = 16;
  localparam int SHW = 5;
  localparam int IW = 10;
  localparam int CA = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          input_valid;
  logic [RW-1:0] input_result;
  logic          index_clear;
  logic [MW-1:0] cfg_mult;
  logic [SHW-1:0] cfg_shift;
  logic [DW-1:0] cfg_zero_point;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_cap;
  logic [DW-1:0] output_value;
  logic [IW-1:0] output_index;
  logic          output_enable;
  logic          output_last;

  int c_mult, c_shift, c_zp, c_mode, c_cap;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int in_q[$];
  int ov_q[$];
  int oi_q[$];
  int ol_q[$];
  int oc_q[$];

  quant_relu_cell #(
    .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .MULT_WIDTH(MW),
    .SHIFT_WIDTH(SHW), .INDEX_WIDTH(IW), .CELL_AMOUNT(CA)
  ) dut (
    .clk(clk), .rst(rst), .input_valid(input_valid), .input_result(input_result),
    .index_clear(index_clear), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
    .cfg_zero_point(cfg_zero_point), .cfg_mode(cfg_mode), .cfg_cap(cfg_cap),
    .output_value(output_value), .output_index(output_index),
    .output_enable(output_enable), .output_last(output_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Capture every output beat; idle beats must be all-zero
  always @(negedge clk) begin
    if (!rst) begin
      if (output_enable) begin
        ov_q.push_back(int'(output_value));
        oi_q.push_back(int'(output_index));
        ol_q.push_back(int'(output_last));
        oc_q.push_back(cyc);
      end else begin
        chk("idle_zero", {output_value, output_index, output_last}, 0);
      end
    end
  end

  task automatic drive(input logic v, input int res, input logic clr);
    @(posedge clk);
    #1;
    input_valid    = v;
    input_result   = RW'(res);
    index_clear    = clr;
    cfg_mult       = MW'(c_mult);
    cfg_shift      = SHW'(c_shift);
    cfg_zero_point = DW'(c_zp);
    cfg_mode       = 2'(c_mode);
    cfg_cap        = DW'(c_cap);
    if (v) in_q.push_back(cyc);
  endtask

  task automatic expect_out(input string tag, input int val, input int idx);
    int t_in;
    for (int i = 0; i < 12 && oc_q.size() == 0; i++) @(negedge clk);
    if (oc_q.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_value"}, ov_q.pop_front(), val);
      chk({tag, "_index"}, oi_q.pop_front(), idx);
      chk({tag, "_last"}, ol_q.pop_front(), (idx == CA - 1) ? 1 : 0);
      t_in = (in_q.size() != 0) ? in_q.pop_front() : -100;
      chk({tag, "_latency"}, oc_q.pop_front() - t_in, 3);
    end
  endtask

  task automatic set_cfg(input int m, input int s, input int z, input int md, input int cp);
    c_mult = m; c_shift = s; c_zp = z; c_mode = md; c_cap = cp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    input_valid = 1'b0; input_result = '0; index_clear = 1'b0;
    cfg_mult = '0; cfg_shift = '0; cfg_zero_point = '0; cfg_mode = 2'd0; cfg_cap = '0;
    set_cfg(16384, 15, 10, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {output_value, output_index, output_enable, output_last}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: ReLU basics
    drive(1'b1, 200, 1'b0);
    drive(1'b1, -200, 1'b0);
    drive(1'b0, 0, 1'b0);
    expect_out("t1_pos", 110, 0);
    expect_out("t1_neg", 10, 1);

    // 2: clamp-only negative, ReLU saturation
    set_cfg(16384, 15, 10, 0, 0);
    drive(1'b1, -200, 1'b0);
    set_cfg(16384, 15, 10, 1, 0);
    drive(1'b1, 1000, 1'b0);
    drive(1'b0, 0, 1'b0);
    expect_out("t2_clamp0", 0, 2);
    expect_out("t2_sat", 255, 3);

    // 3: rounding half toward +inf, zero shift
    set_cfg(1, 1, 128, 0, 0);
    drive(1'b1, 3, 1'b0);
    drive(1'b1, -3, 1'b0);
    drive(1'b1, 2, 1'b0);
    set_cfg(1, 0, 128, 0, 0);
    drive(1'b1, 5, 1'b0);
    drive(1'b0, 0, 1'b0);
    expect_out("t3_p3", 130, 0);
    expect_out("t3_m3", 127, 1);
    expect_out("t3_p2", 129, 2);
    expect_out("t3_sh0", 133, 3);

    // 4: capped ReLU, cap below zero point, mode 3 as ReLU
    set_cfg(16384, 15, 10, 2, 60);
    drive(1'b1, 200, 1'b0);
    set_cfg(16384, 15, 10, 2, 5);
    drive(1'b1, 200, 1'b0);
    set_cfg(16384, 15, 10, 3, 0);
    drive(1'b1, -200, 1'b0);
    drive(1'b0, 0, 1'b0);
    expect_out("t4_cap", 60, 0);
    expect_out("t4_lowin", 10, 1);
    expect_out("t4_mode3", 10, 2);

    // 5: index wrap across a gap, clear with and without a valid
    set_cfg(1, 0, 0, 0, 0);
    drive(1'b1, 1, 1'b1);
    drive(1'b1, 2, 1'b0);
    drive(1'b1, 3, 1'b0);
    drive(1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b0);
    drive(1'b1, 4, 1'b0);
    drive(1'b1, 5, 1'b0);
    drive(1'b1, 6, 1'b0);
    drive(1'b1, 7, 1'b1);
    drive(1'b0, 0, 1'b1);
    drive(1'b1, 8, 1'b0);
    drive(1'b0, 0, 1'b0);
    expect_out("t5_a", 1, 0);
    expect_out("t5_b", 2, 1);
    expect_out("t5_c", 3, 2);
    expect_out("t5_d", 4, 3);
    expect_out("t5_e", 5, 0);
    expect_out("t5_f", 6, 1);
    expect_out("t5_clrv", 7, 0);
    expect_out("t5_clr", 8, 0);

    // 6: asynchronous reset flushes three in-flight samples
    drive(1'b1, 11, 1'b0);
    drive(1'b1, 12, 1'b0);
    drive(1'b1, 13, 1'b0);
    drive(1'b0, 0, 1'b0);
    chk("t6_busy", output_enable, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async", {output_value, output_index, output_enable, output_last}, 0);
    in_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    chk("t6_flushed", oc_q.size(), 0);
    drive(1'b1, 20, 1'b0);
    drive(1'b0, 0, 1'b0);
    expect_out("t6_after", 20, 0);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
